// File: rtl/spi_mem_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// spi_mem_pkg
// Shared types for the SPI-to-memory command sequencer.
//   CTRL_WIDTH   : width of the command field at the top of each SPI frame
//   cmd_t        : frame command encoding
//   ctrl_state_t : sequencer states
// -----------------------------------------------------------------------------
package spi_mem_pkg;

  localparam int CTRL_WIDTH = 2;

  typedef enum logic [CTRL_WIDTH-1:0] {
    CMD_WR_ADDR = 2'b00,
    CMD_WR_DATA = 2'b01,
    CMD_RD_ADDR = 2'b10,
    CMD_RD_DATA = 2'b11
  } cmd_t;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WR_MEM   = 3'd1,
    RD_ISSUE = 3'd2,
    RD_WAIT  = 3'd3,
    TX_HOLD  = 3'd4
  } ctrl_state_t;

endpackage

// File: rtl/spi_mem_ctrl_if.sv
// -----------------------------------------------------------------------------
// spi_mem_ctrl_if
// Bundles the SPI-slave frame side and the memory side of spi_mem_ctrl.
//   rx_valid/rx_data   : frame from the SPI slave ({cmd, payload})
//   tx_valid/tx_data   : read data back to the SPI slave
//   mem_en/we/addr/... : single-port synchronous memory
//   busy/cmd_err       : status
// Modports:
//   slave  : the controller (consumes frames, masters the memory)
//   master : the environment (SPI slave + memory + status observer)
// -----------------------------------------------------------------------------
interface spi_mem_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
);

  logic                                        rx_valid;
  logic [DATA_WIDTH+spi_mem_pkg::CTRL_WIDTH-1:0] rx_data;
  logic                                        tx_valid;
  logic [DATA_WIDTH-1:0]                       tx_data;
  logic                                        mem_en;
  logic                                        mem_we;
  logic [ADDR_WIDTH-1:0]                       mem_addr;
  logic [DATA_WIDTH-1:0]                       mem_wdata;
  logic [DATA_WIDTH-1:0]                       mem_rdata;
  logic                                        busy;
  logic                                        cmd_err;

  modport slave (
    input  rx_valid, rx_data, mem_rdata,
    output tx_valid, tx_data, mem_en, mem_we, mem_addr, mem_wdata, busy, cmd_err
  );

  modport master (
    output rx_valid, rx_data, mem_rdata,
    input  tx_valid, tx_data, mem_en, mem_we, mem_addr, mem_wdata, busy, cmd_err
  );

endinterface

// File: rtl/spi_mem_ctrl.sv
// -----------------------------------------------------------------------------
// spi_mem_ctrl
// Command decoder / sequencer between an SPI slave frame interface and a
// synchronous single-port memory. Frames are {cmd[1:0], payload}:
//   00 WR_ADDR : load write address
//   01 WR_DATA : write payload at write address (strobe next cycle)
//   10 RD_ADDR : load read address, mark it valid
//   11 RD_DATA : read at read address, return data on tx_valid/tx_data
// Ports:
//   clk   : clock, rising edge
//   rst_n : synchronous, active-low reset
//   bus   : spi_mem_ctrl_if.slave (frame, tx, memory and status signals)
// Parameters: DATA_WIDTH, ADDR_WIDTH (must match), RD_LATENCY (1..4).
// Optional build macro SPI_MEM_AUTO_INC_EN: post-increment both addresses
// after each access and keep the read address valid for streaming reads.
// -----------------------------------------------------------------------------
module spi_mem_ctrl
  import spi_mem_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int RD_LATENCY = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  spi_mem_ctrl_if.slave bus
);

  // The address is carried in the payload, so the widths must agree.
  if (ADDR_WIDTH != DATA_WIDTH) begin : g_bad_width
    $error("spi_mem_ctrl: ADDR_WIDTH must equal DATA_WIDTH");
  end
  if (RD_LATENCY < 1 || RD_LATENCY > 4) begin : g_bad_lat
    $error("spi_mem_ctrl: RD_LATENCY must be in 1..4");
  end

  localparam int                CNT_W    = 2;
  localparam logic [CNT_W-1:0]  LAT_LOAD = CNT_W'(RD_LATENCY - 1);

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  ctrl_state_t           state_q, state_d;
  logic                  rx_prev_q, rx_prev_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic                  rd_addr_vld_q, rd_addr_vld_d;
  logic [CNT_W-1:0]      lat_cnt_q, lat_cnt_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
  logic                  cmd_err_q, cmd_err_d;

  // Frame decode
  logic                  frame_evt;
  cmd_t                  cmd;
  logic [DATA_WIDTH-1:0] payload;
  logic                  rd_done;

  assign frame_evt = bus.rx_valid & ~rx_prev_q;
  assign cmd       = cmd_t'(bus.rx_data[DATA_WIDTH+CTRL_WIDTH-1:DATA_WIDTH]);
  assign payload   = bus.rx_data[DATA_WIDTH-1:0];
  // Last RD_WAIT cycle: mem_rdata is valid now.
  assign rd_done   = (state_q == RD_WAIT) && (lat_cnt_q == '0);

  // ---------------------------------------------------------------------------
  // State register (plus all datapath flops)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      rx_prev_q     <= 1'b0;
      wr_addr_q     <= '0;
      rd_addr_q     <= '0;
      rd_addr_vld_q <= 1'b0;
      lat_cnt_q     <= '0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      tx_data_q     <= '0;
      cmd_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      rx_prev_q     <= rx_prev_d;
      wr_addr_q     <= wr_addr_d;
      rd_addr_q     <= rd_addr_d;
      rd_addr_vld_q <= rd_addr_vld_d;
      lat_cnt_q     <= lat_cnt_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      tx_data_q     <= tx_data_d;
      cmd_err_q     <= cmd_err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (frame_evt) begin
          if (cmd == CMD_WR_DATA)      state_d = WR_MEM;
          else if (cmd == CMD_RD_DATA) state_d = RD_ISSUE;
        end
      end
      WR_MEM:   state_d = IDLE;
      RD_ISSUE: state_d = RD_WAIT;
      RD_WAIT: begin
        // A master that already released rx_valid gets nothing back.
        if (rd_done) state_d = bus.rx_valid ? TX_HOLD : IDLE;
      end
      TX_HOLD: begin
        if (!bus.rx_valid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output / datapath logic
  // ---------------------------------------------------------------------------
  always_comb begin
    rx_prev_d     = bus.rx_valid;
    wr_addr_d     = wr_addr_q;
    rd_addr_d     = rd_addr_q;
    rd_addr_vld_d = rd_addr_vld_q;
    lat_cnt_d     = lat_cnt_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    tx_data_d     = tx_data_q;
    cmd_err_d     = cmd_err_q;

    // Frames arriving while a previous command is still in flight are lost.
    if (frame_evt && state_q != IDLE) cmd_err_d = 1'b1;

    unique case (state_q)
      IDLE: begin
        if (frame_evt) begin
          unique case (cmd)
            CMD_WR_ADDR: wr_addr_d = payload;
            CMD_RD_ADDR: begin
              rd_addr_d     = payload;
              rd_addr_vld_d = 1'b1;
            end
            CMD_WR_DATA: begin
              // Address/data are registered here so they are already on the
              // bus during the WR_MEM strobe cycle.
              mem_wdata_d = payload;
              mem_addr_d  = wr_addr_q;
            end
            CMD_RD_DATA: begin
              // Reading without a fresh RD_ADDR is flagged but still executed.
              if (!rd_addr_vld_q) cmd_err_d = 1'b1;
              mem_addr_d = rd_addr_q;
            end
          endcase
        end
      end
      WR_MEM: begin
`ifdef SPI_MEM_AUTO_INC_EN
        wr_addr_d = wr_addr_q + 1'b1;
`endif
      end
      RD_ISSUE: lat_cnt_d = LAT_LOAD;
      RD_WAIT: begin
        if (rd_done) begin
          tx_data_d = bus.mem_rdata;
`ifdef SPI_MEM_AUTO_INC_EN
          rd_addr_d = rd_addr_q + 1'b1;
`else
          rd_addr_vld_d = 1'b0;
`endif
        end else begin
          lat_cnt_d = lat_cnt_q - 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Strobes and status decode directly from the state.
  assign bus.mem_en    = (state_q == WR_MEM) || (state_q == RD_ISSUE);
  assign bus.mem_we    = (state_q == WR_MEM);
  assign bus.tx_valid  = (state_q == TX_HOLD);
  assign bus.busy      = (state_q != IDLE);
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.tx_data   = tx_data_q;
  assign bus.cmd_err   = cmd_err_q;

endmodule

// File: tb/tb_spi_mem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_spi_mem_ctrl
// Scoreboard bench for spi_mem_ctrl: stimulus tasks update a behavioural model
// (address registers, shadow memory, error flag) and push expected memory
// strobes and read responses into queues; a negedge monitor pops and compares
// whenever the DUT strobes the memory or raises tx_valid.
// -----------------------------------------------------------------------------
module tb_spi_mem_ctrl;

  localparam int DW     = 8;
  localparam int AW     = 8;
  localparam int RD_LAT = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_mem_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  spi_mem_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(RD_LAT)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Memory device: synchronous, RD_LAT cycles from strobe to valid data
  // ---------------------------------------------------------------------------
  function automatic logic [7:0] init_val(input int a);
    return 8'((a * 37 + 91) & 255);
  endfunction

  logic [DW-1:0] mem   [256];
  logic [DW-1:0] rpipe [RD_LAT];
  logic          preload = 1'b1;

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
    end else if (bus.mem_en && bus.mem_we) begin
      mem[bus.mem_addr] <= bus.mem_wdata;
    end
    if (bus.mem_en && !bus.mem_we) rpipe[0] <= mem[bus.mem_addr];
    for (int i = 1; i < RD_LAT; i++) rpipe[i] <= rpipe[i-1];
  end
  assign bus.mem_rdata = rpipe[RD_LAT-1];

  // ---------------------------------------------------------------------------
  // Reference model and scoreboard queues
  // ---------------------------------------------------------------------------
  logic [7:0]  m_wr, m_rd;
  bit          m_vld, m_err;
  logic [7:0]  ref_mem [256];
  logic [15:0] exp_wr_q [$];
  logic [7:0]  exp_rd_q [$];
  logic [7:0]  exp_tx_q [$];

  task automatic model_reset();
    m_wr = 8'h00; m_rd = 8'h00; m_vld = 1'b0; m_err = 1'b0;
    exp_wr_q.delete(); exp_rd_q.delete(); exp_tx_q.delete();
  endtask

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  logic        tx_prev = 1'b0;
  logic [15:0] mon_w;
  logic [7:0]  mon_b;

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.mem_en && bus.mem_we) begin
        if (exp_wr_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL wr_strobe: unexpected write addr 0x%0h data 0x%0h", bus.mem_addr, bus.mem_wdata);
        end else begin
          mon_w = exp_wr_q.pop_front();
          chk("wr_addr", bus.mem_addr, mon_w[15:8]);
          chk("wr_data", bus.mem_wdata, mon_w[7:0]);
        end
      end
      if (bus.mem_en && !bus.mem_we) begin
        if (exp_rd_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL rd_strobe: unexpected read addr 0x%0h", bus.mem_addr);
        end else begin
          mon_b = exp_rd_q.pop_front();
          chk("rd_addr", bus.mem_addr, mon_b);
        end
      end
      if (bus.tx_valid && !tx_prev) begin
        if (exp_tx_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL tx_valid: unexpected response data 0x%0h", bus.tx_data);
        end else begin
          mon_b = exp_tx_q.pop_front();
          chk("tx_data", bus.tx_data, mon_b);
        end
      end
      tx_prev <= bus.tx_valid;
    end else begin
      tx_prev <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus tasks (all start and end at posedge + 1)
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; bus.rx_valid = 1'b0; bus.rx_data = '0;
    model_reset();
    step(); step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_tx_valid", bus.tx_valid, 0);
    chk("rst_tx_data", bus.tx_data, 0);
    chk("rst_mem_en", bus.mem_en, 0);
    chk("rst_mem_we", bus.mem_we, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_mem_wdata", bus.mem_wdata, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_cmd_err", bus.cmd_err, 0);
    step();
  endtask

  // Non-read frames: WR_ADDR, WR_DATA, RD_ADDR
  task automatic send(input logic [1:0] cmd, input logic [7:0] pl);
    case (cmd)
      2'b00: m_wr = pl;
      2'b01: begin
        exp_wr_q.push_back({m_wr, pl});
        ref_mem[m_wr] = pl;
`ifdef SPI_MEM_AUTO_INC_EN
        m_wr = m_wr + 8'd1;
`endif
      end
      2'b10: begin m_rd = pl; m_vld = 1'b1; end
      default: ;
    endcase
    bus.rx_data = {cmd, pl}; bus.rx_valid = 1'b1;
    step(); step();
    bus.rx_valid = 1'b0;
    step(); step(); step();
    @(negedge clk);
    chk("cmd_err", bus.cmd_err, m_err);
    chk("busy_idle", bus.busy, 0);
    step();
  endtask

  // RD_DATA frame. mode 0: normal, 1: master aborts during the wait,
  // 2: rx_valid glitches so a second frame edge lands mid-read.
  // keep_hold leaves the DUT in TX_HOLD with rx_valid still high.
  task automatic rd(input int mode, input bit keep_hold);
    int first;
    first = -1;
    if (!m_vld) m_err = 1'b1;
    exp_rd_q.push_back(m_rd);
    if (mode != 1) exp_tx_q.push_back(ref_mem[m_rd]);
    if (mode == 2) m_err = 1'b1;
`ifdef SPI_MEM_AUTO_INC_EN
    m_rd = m_rd + 8'd1;
`else
    m_vld = 1'b0;
`endif
    bus.rx_data = {2'b11, 8'($urandom)};
    for (int k = 0; k <= RD_LAT + 6; k++) begin
      if (k > 0) step();
      case (mode)
        1:       bus.rx_valid = (k < 2);
        2:       bus.rx_valid = (k != 1);
        default: bus.rx_valid = 1'b1;
      endcase
      @(negedge clk);
      if (bus.tx_valid && first < 0) first = k;
    end
    chk("cmd_err_rd", bus.cmd_err, m_err);
    if (mode == 1) begin
      chk("abort_no_tx", first, -1);
      chk("abort_busy", bus.busy, 0);
      step();
    end else begin
      chk("tx_latency", first, RD_LAT + 2);
      step();
      if (!keep_hold) begin
        bus.rx_valid = 1'b0;
        @(negedge clk);
        chk("tx_hold_at_drop", bus.tx_valid, 1);
        step();
        @(negedge clk);
        chk("tx_drop", bus.tx_valid, 0);
        chk("idle_after_tx", bus.busy, 0);
        step();
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    int op;
    int r;
    logic [7:0] pl;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
    bus.rx_valid = 1'b0; bus.rx_data = '0;
    model_reset();
    step();
    do_reset();
    preload = 1'b0;

    // Basic write then read back
    send(2'b00, 8'h3C);
    send(2'b01, 8'hA5);
    send(2'b10, 8'h3C);
    rd(0, 1'b0);

    // Read without RD_ADDR (address 0, error), then reset while holding tx
    do_reset();
    rd(0, 1'b1);
    rst_n = 1'b0; bus.rx_valid = 1'b0;
    model_reset();
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("hold_rst_tx_valid", bus.tx_valid, 0);
    chk("hold_rst_mem_en", bus.mem_en, 0);
    chk("hold_rst_busy", bus.busy, 0);
    chk("hold_rst_cmd_err", bus.cmd_err, 0);
    step();

    // cmd_err is sticky across later good frames
    rd(0, 1'b0);
    send(2'b00, 8'h05);
    send(2'b01, 8'h77);

    // Abort during the wait, then a mid-read frame edge
    do_reset();
    send(2'b10, 8'h10);
    rd(1, 1'b0);
    send(2'b10, 8'h3C);
    rd(2, 1'b0);

    // Address wrap (streaming with auto-increment)
    do_reset();
    send(2'b00, 8'hFF);
    send(2'b01, 8'h11);
    send(2'b01, 8'h22);
    send(2'b10, 8'hFF);
    rd(0, 1'b0);
    rd(0, 1'b0);

    // Randomized traffic
    do_reset();
    for (int n = 0; n < 60; n++) begin
      op = $urandom_range(0, 3);
      pl = 8'($urandom);
      if ($urandom_range(0, 3) == 0) pl = 8'($urandom_range(0, 3)); // cluster addresses
      if (op == 3) begin
        r = $urandom_range(0, 9);
        rd((r == 0) ? 1 : (r == 1) ? 2 : 0, 1'b0);
      end else begin
        send(2'(op), pl);
      end
      if ($urandom_range(0, 29) == 0) do_reset();
    end

    step(); step();
    chk("wr_q_empty", exp_wr_q.size(), 0);
    chk("rd_q_empty", exp_rd_q.size(), 0);
    chk("tx_q_empty", exp_tx_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/spi_mem_ctrl.md
Name: spi_mem_ctrl

Overview:
Command decoder and sequencer between the SPI slave frame interface and a synchronous single-port memory. It receives 10-bit frames made of a 2-bit command and 8 bits of payload. It maintains separate write and read address registers, issues one-cycle memory write and read strobes, waits out the memory read latency, and returns read data to the SPI slave through tx_valid/tx_data. It is the sole memory master in the SPI-to-RAM subsystem.

Parameters:
DATA_WIDTH, 8, memory word width and SPI payload width
ADDR_WIDTH, 8, memory address width; must equal DATA_WIDTH (address travels in the payload field)
RD_LATENCY, 1, memory read latency in clk cycles from mem_en to valid mem_rdata; legal range 1..4

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
rx_valid  in  1  SPI slave frame-complete level; stays high until the SPI transaction ends
rx_data  in  DATA_WIDTH+2  [DATA_WIDTH+1:DATA_WIDTH] = command, [DATA_WIDTH-1:0] = payload
tx_valid  out  1  read data available to the SPI slave
tx_data  out  DATA_WIDTH  read data returned to the SPI slave
mem_en  out  1  memory access strobe, one cycle per access
mem_we  out  1  1 = write, 0 = read; qualified by mem_en
mem_addr  out  ADDR_WIDTH  memory address
mem_wdata  out  DATA_WIDTH  memory write data
mem_rdata  in  DATA_WIDTH  memory read data, valid RD_LATENCY cycles after the read strobe
busy  out  1  high in any state other than IDLE
cmd_err  out  1  sticky protocol-error flag; cleared only by reset

Behaviour:
- Reset (clk edge with rst_n = 0) sets all outputs, wr_addr, rd_addr and rd_addr_vld to 0, and the state to IDLE. Reset mid-operation aborts any access; no strobe is issued afterwards.
- A frame event is the rising edge of rx_valid, detected with a registered copy (rx_valid = 1, previous value = 0). The controller acts only on events that occur in IDLE.
- Commands: 00 = WR_ADDR, 01 = WR_DATA, 10 = RD_ADDR, 11 = RD_DATA.
- IDLE, event WR_ADDR: wr_addr <= payload. Stay in IDLE.
- IDLE, event RD_ADDR: rd_addr <= payload; rd_addr_vld <= 1. Stay in IDLE.
- IDLE, event WR_DATA: latch the payload into mem_wdata and go to WR_MEM.
- IDLE, event RD_DATA: go to RD_ISSUE. If rd_addr_vld = 0, set cmd_err; the read still proceeds using the current rd_addr.
- WR_MEM, one cycle: mem_en = 1, mem_we = 1, mem_addr = wr_addr. Then go to IDLE. The write strobe appears in the cycle after the event.
- RD_ISSUE, one cycle: mem_en = 1, mem_we = 0, mem_addr = rd_addr. Load the latency counter and go to RD_WAIT.
- RD_WAIT: count RD_LATENCY cycles. In the cycle where mem_rdata is valid, register tx_data <= mem_rdata.
  - If rx_valid is still 1: go to TX_HOLD.
  - If rx_valid is 0 (master aborted): go to IDLE without ever asserting tx_valid.
  - rd_addr_vld <= 0 on exit.
- TX_HOLD: tx_valid = 1, tx_data stable. When rx_valid = 0 is sampled, tx_valid drops the next cycle and the state returns to IDLE. tx_data keeps its last value.
- Read timing: tx_valid first goes high RD_LATENCY+2 cycles after the RD_DATA event cycle.
- mem_en is 0 outside WR_MEM and RD_ISSUE. mem_addr and mem_wdata hold their last values.
- A frame event seen outside IDLE is dropped and sets cmd_err.
- Address registers are ADDR_WIDTH wide with no saturation; arithmetic wraps modulo 2**ADDR_WIDTH.

Optional Feature:
Macro SPI_MEM_AUTO_INC_EN.
- Defined:
  - wr_addr increments by 1 after each WR_MEM cycle.
  - rd_addr increments by 1 on exit from RD_WAIT, and rd_addr_vld stays 1, so consecutive RD_DATA frames stream without cmd_err.
  - Address 2**ADDR_WIDTH-1 wraps to 0.
- Undefined: addresses change only on WR_ADDR/RD_ADDR, and rd_addr_vld clears after every read.

Decomposition:
- Package spi_mem_pkg contains:
  - CTRL_WIDTH = 2
  - cmd_t enum: CMD_WR_ADDR = 2'b00, CMD_WR_DATA = 2'b01, CMD_RD_ADDR = 2'b10, CMD_RD_DATA = 2'b11
  - ctrl_state_t enum: IDLE, WR_MEM, RD_ISSUE, RD_WAIT, TX_HOLD
- No sub-module. The edge detect and latency counter are too small to justify one; a single module is used.

Test Plan:
- Frames 00_0x3C then 01_0xA5 -> one cycle with mem_en = 1, mem_we = 1, mem_addr = 0x3C, mem_wdata = 0xA5, occurring the cycle after the second rx_valid rise; cmd_err = 0.
- Memory preloaded [0x3C] = 0xA5, RD_LATENCY = 2; frames 10_0x3C then 11_0x00 -> read strobe at addr 0x3C; tx_valid rises 4 cycles after the event with tx_data = 0xA5; held until rx_valid falls, then drops 1 cycle later.
- RD_DATA with no preceding RD_ADDR after reset -> read of address 0x00 is performed and cmd_err = 1, sticky until rst_n = 0.
- RD_DATA issued, rx_valid dropped during RD_WAIT -> tx_valid never asserts; state returns to IDLE with busy = 0.
- rst_n = 0 asserted during TX_HOLD -> next cycle tx_valid = 0, mem_en = 0, busy = 0, cmd_err = 0.
- SPI_MEM_AUTO_INC_EN defined: WR_ADDR 0xFF, then WR_DATA 0x11 and WR_DATA 0x22 -> writes land at 0xFF and 0x00 (wrap); two RD_DATA frames after RD_ADDR 0xFF return 0x11 then 0x22 with cmd_err = 0.
